// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed 7-segment scanner with blank gaps and frame-synchronous double-buffered display updates.
module hex_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   val,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [3:0]            dec_x,
  input  logic [0:6]            dec_h,
  output logic [DIGITS-1:0]     an,
  output logic [0:6]            seg,
  output logic                  ack
);
  localparam int CW = $clog2((DIV > GAP ? DIV : GAP) + 1);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic [3:0]          dec_x_q, dec_x_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [0:6]          seg_q, seg_d;
  logic                ack_q, ack_d;
  logic                last_gap, last_show, wrap;

  always_comb begin
    last_gap  = state_q == S_GAP && cnt_q == CW'(GAP - 1);
    last_show = state_q == S_SHOW && cnt_q == CW'(DIV - 1);
    wrap      = last_show && idx_q == IW'(DIGITS - 1);
    state_d   = last_gap ? S_SHOW : last_show ? S_GAP : state_q;
    cnt_d     = (last_gap || last_show) ? '0 : cnt_q + 1'b1;
    idx_d     = last_show ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    an_d      = last_gap ? (blank_mask[idx_q] ? '1 : ~(DIGITS'(1) << idx_q)) : last_show ? '1 : an_q;
    seg_d     = last_gap ? (blank_mask[idx_q] ? '1 : dec_h) : last_show ? '1 : seg_q;
    // a load landing on the wrap cycle goes straight to the display
    ack_d     = wrap && (load || pend_q);
    disp_d    = ack_d ? (load ? val : shadow_q) : disp_q;
    shadow_d  = load ? val : shadow_q;
    pend_d    = ack_d ? 1'b0 : (load | pend_q);
    dec_x_d   = disp_d[4*idx_d +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GAP;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      dec_x_q  <= '0;
      an_q     <= '1;
      seg_q    <= '1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      dec_x_q  <= dec_x_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      ack_q    <= ack_d;
    end
  end

  assign dec_x = dec_x_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign ack   = ack_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed table plus randomized stimulus against a frame-arithmetic reference model.
module tb_hex_scan_ctrl;
  localparam int D = 4, V = 4, G = 1, P = G + V, F = D * P;

  logic        clk = 1'b0, rst, load, ack;
  logic [15:0] val;
  logic [3:0]  blank_mask, an, dec_x;
  logic [0:6]  dec_h, seg;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIGITS(D), .DIV(V), .GAP(G)) dut (
    .clk(clk), .rst(rst), .val(val), .load(load), .blank_mask(blank_mask),
    .dec_x(dec_x), .dec_h(dec_h), .an(an), .seg(seg), .ack(ack)
  );

  function automatic logic [0:6] hex7(input logic [3:0] x);
    case (x)
      4'h0: hex7 = 7'b0000001; 4'h1: hex7 = 7'b1001111; 4'h2: hex7 = 7'b0010010; 4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100; 4'h5: hex7 = 7'b0100100; 4'h6: hex7 = 7'b0100000; 4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000; 4'h9: hex7 = 7'b0000100; 4'hA: hex7 = 7'b0001000; 4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001; 4'hD: hex7 = 7'b1000010; 4'hE: hex7 = 7'b0110000; default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign dec_h = hex7(dec_x);

  typedef struct { int k; logic [3:0] an; logic [6:0] seg; logic ack; } exp_t;
  typedef struct { int k; logic l; logic [15:0] v; logic r; } stim_t;

  localparam int NE = 29, NS = 6;
  exp_t  et [NE];
  stim_t st [NS];

  int errs = 0, checks = 0;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, m_ack, m_blank;
  int          mt;
  logic [3:0]  cur_mask;

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_shadow = 0; m_pend = 0; m_ack = 0; m_blank = 0; mt = 0;
  endtask

  task automatic model_check(input int k);
    int r, d, ph;
    logic lit;
    r = mt % F; d = r / P; ph = r % P;
    lit = ph >= G && !m_blank;
    chk("an", k, {12'b0, an}, {12'b0, lit ? ~(4'b1 << d) : 4'hF});
    chk("seg", k, {9'b0, seg}, {9'b0, lit ? hex7(m_disp[4*d +: 4]) : 7'h7F});
    chk("dec_x", k, {12'b0, dec_x}, {12'b0, m_disp[4*d +: 4]});
    chk("ack", k, {15'b0, ack}, {15'b0, m_ack});
  endtask

  task automatic model_step(input logic l, input logic [15:0] v, input logic [3:0] m, input logic r);
    int rr, d, ph;
    if (r) begin
      model_reset();
      return;
    end
    rr = mt % F; d = rr / P; ph = rr % P;
    m_ack = 0;
    if (ph == G - 1) m_blank = m[d];
    if (rr == F - 1 && (l || m_pend)) begin
      m_disp = l ? v : m_shadow;
      m_pend = 0;
      m_ack  = 1;
    end else if (l) begin
      m_shadow = v;
      m_pend   = 1;
    end
    mt++;
  endtask

  task automatic cycle(input int k, input logic l, input logic [15:0] v, input logic [3:0] m, input logic r);
    model_check(k);
    rst = r; load = l; val = v; blank_mask = m;
    model_step(l, v, m, r);
    @(negedge clk);
  endtask

  initial begin
    et = '{
      '{0, 4'hF, 7'h7F, 1'b0}, '{1, 4'hE, 7'h01, 1'b0}, '{4, 4'hE, 7'h01, 1'b0}, '{5, 4'hF, 7'h7F, 1'b0},
      '{6, 4'hD, 7'h01, 1'b0}, '{9, 4'hD, 7'h01, 1'b0}, '{16, 4'h7, 7'h01, 1'b0}, '{19, 4'h7, 7'h01, 1'b0},
      '{20, 4'hF, 7'h7F, 1'b1}, '{21, 4'hE, 7'h01, 1'b0}, '{26, 4'hD, 7'h4F, 1'b0}, '{31, 4'hB, 7'h12, 1'b0},
      '{36, 4'h7, 7'h06, 1'b0}, '{46, 4'hD, 7'h4F, 1'b0}, '{51, 4'hF, 7'h7F, 1'b0}, '{54, 4'hF, 7'h7F, 1'b0},
      '{56, 4'h7, 7'h06, 1'b0}, '{79, 4'h7, 7'h06, 1'b0}, '{80, 4'hF, 7'h7F, 1'b1}, '{81, 4'hE, 7'h08, 1'b0},
      '{96, 4'h7, 7'h08, 1'b0}, '{100, 4'hF, 7'h7F, 1'b1}, '{101, 4'hE, 7'h12, 1'b0}, '{106, 4'hD, 7'h12, 1'b0},
      '{111, 4'hB, 7'h12, 1'b0}, '{113, 4'hF, 7'h7F, 1'b0}, '{114, 4'hE, 7'h01, 1'b0}, '{129, 4'h7, 7'h01, 1'b0},
      '{133, 4'hF, 7'h7F, 1'b0}
    };
    st = '{
      '{3, 1'b1, 16'h3210, 1'b0}, '{79, 1'b1, 16'hAAAA, 1'b0}, '{82, 1'b1, 16'h1111, 1'b0},
      '{90, 1'b1, 16'h2222, 1'b0}, '{103, 1'b1, 16'h5555, 1'b0}, '{112, 1'b0, 16'h0000, 1'b1}
    };
    rst = 1; load = 0; val = 0; blank_mask = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 0;
    for (int k = 0; k < 140; k++) begin
      logic l, r;
      logic [15:0] v;
      l = 0; r = 0; v = 0;
      for (int i = 0; i < NE; i++)
        if (et[i].k == k) begin
          chk("tbl_an", k, {12'b0, an}, {12'b0, et[i].an});
          chk("tbl_seg", k, {9'b0, seg}, {9'b0, et[i].seg});
          chk("tbl_ack", k, {15'b0, ack}, {15'b0, et[i].ack});
        end
      for (int i = 0; i < NS; i++)
        if (st[i].k == k) begin
          l = st[i].l; v = st[i].v; r = st[i].r;
        end
      cycle(k, l, v, (k >= 40 && k < 60) ? 4'b0100 : 4'b0000, r);
    end
    cur_mask = 0;
    for (int k = 140; k < 540; k++) begin
      if ($urandom_range(0, 3) == 0) cur_mask = 4'($urandom);
      cycle(k, $urandom_range(0, 7) == 0, 16'($urandom), cur_mask, $urandom_range(0, 149) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
